// File: rtl/interp_upsampler_if.sv
// Signal bundle between the upstream sample FIFO / mode control and the
// interpolating upsampler that feeds the DAC data path.
interface interp_upsampler_if #(
  parameter int DATA_WIDTH = 14
);
  logic                         ena;        // FIFO above-half flag, start condition
  logic                         empty;      // FIFO empty flag
  logic [1:0]                   mode;       // 0 bypass, 1 zero-stuff, 2 hold, 3 linear
  logic                         rd_en;      // FIFO read enable (read latency 1)
  logic signed [DATA_WIDTH-1:0] dataIn;     // FIFO read data
  logic signed [DATA_WIDTH-1:0] inter_data; // interpolated output sample
  logic                         out_valid;  // inter_data qualifier
  logic                         underflow;  // sticky underflow flag

  // Environment side: drives FIFO flags, FIFO data and mode; observes outputs.
  modport master (
    output ena, empty, mode, dataIn,
    input  rd_en, inter_data, out_valid, underflow
  );

  // Upsampler side.
  modport slave (
    input  ena, empty, mode, dataIn,
    output rd_en, inter_data, out_valid, underflow
  );
endinterface

// File: rtl/interp_upsampler.sv
// Interpolating upsampler: reads signed samples from a FIFO and emits one
// output sample per clock at L = 2^FACTOR_LOG2 times the input rate, using
// bypass, zero-stuff, hold or linear interpolation. Detects FIFO underflow
// (sticky) and qualifies the output stream with out_valid.
module interp_upsampler #(
  parameter int DATA_WIDTH  = 14,
  parameter int FACTOR_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  interp_upsampler_if.slave bus
);

  localparam int PW     = FACTOR_LOG2;
  localparam int PROD_W = DATA_WIDTH + 1 + FACTOR_LOG2;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  typedef enum logic [1:0] {
    M_BYPASS = 2'd0,
    M_ZERO   = 2'd1,
    M_HOLD   = 2'd2,
    M_LINEAR = 2'd3
  } mode_e;

  // Control state
  state_e                       state_q, state_d;
  mode_e                        mode_q, mode_d;
  logic [PW-1:0]                phase_q, phase_d;
  logic                         underflow_q, underflow_d;

  // Capture stage
  logic                         vld_q;
  logic signed [DATA_WIDTH-1:0] x_prev_q, x_prev_d;
  logic signed [DATA_WIDTH-1:0] x_cur_q, x_cur_d;

  // Output stage
  logic [PW-1:0]                k_q, k_d;
  logic                         seg_q, seg_d;
  logic signed [DATA_WIDTH-1:0] inter_q, inter_d;
  logic                         out_valid_q, out_valid_d;

  // Decoded strobes
  logic [PW-1:0]                last_idx;
  logic                         start;
  logic                         slot;
  logic                         rd_en;
  logic                         underrun;

  // Linear interpolation datapath
  logic signed [DATA_WIDTH:0]   diff;
  logic signed [PROD_W-1:0]     diff_ext;
  logic signed [PROD_W-1:0]     k_ext;
  logic signed [PROD_W-1:0]     x_prev_ext;
  logic signed [PROD_W-1:0]     prod;
  logic signed [DATA_WIDTH-1:0] lin_val;

  // Leff-1: a single output per sample in bypass, L-1 (all ones) otherwise.
  assign last_idx = (mode_q == M_BYPASS) ? '0 : '1;

  assign start    = (state_q == S_IDLE) & bus.ena & ~bus.empty;
  assign slot     = (state_q == S_RUN) & (phase_q == '0);
  assign rd_en    = slot & ~bus.empty;
  assign underrun = slot & bus.empty;

  // Linear step: the difference needs one extra bit, the product FACTOR_LOG2
  // more; the arithmetic shift floors. The sum always lies between x_prev and
  // x_cur, so narrowing back to DATA_WIDTH cannot overflow.
  assign diff       = {x_cur_q[DATA_WIDTH-1], x_cur_q} - {x_prev_q[DATA_WIDTH-1], x_prev_q};
  assign diff_ext   = {{FACTOR_LOG2{diff[DATA_WIDTH]}}, diff};
  assign k_ext      = {{(DATA_WIDTH+1){1'b0}}, k_q};
  assign x_prev_ext = {{(FACTOR_LOG2+1){x_prev_q[DATA_WIDTH-1]}}, x_prev_q};
  assign prod       = diff_ext * k_ext;
  assign lin_val    = DATA_WIDTH'(x_prev_ext + (prod >>> FACTOR_LOG2));

  // FSM next state: start on above-half with data, leave RUN only on underflow.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // block leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    mode_d      = mode_q;
    phase_d     = phase_q;
    underflow_d = underflow_q;
    case (state_q)
      S_IDLE: begin
        phase_d = '0;
        if (start) begin
          state_d = S_RUN;
          mode_d  = mode_e'(bus.mode);
        end
      end
      S_RUN: begin
        if (underrun) begin
          state_d     = S_IDLE;
          phase_d     = '0;
          underflow_d = 1'b1;
        end else if (phase_q == last_idx) begin
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before the edge, independent of statement order.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= M_BYPASS;
      phase_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      phase_q     <= phase_d;
      underflow_q <= underflow_d;
    end
  end

  // Sample capture: a fresh run ramps from zero; otherwise shift in the new sample.
  always_comb begin
    x_prev_d = x_prev_q;
    x_cur_d  = x_cur_q;
    if (start) begin
      x_prev_d = '0;
      x_cur_d  = '0;
    end else if (vld_q) begin
      x_prev_d = x_cur_q;
      x_cur_d  = bus.dataIn;
    end
  end

  // Segment sequencing: each captured sample opens a segment of Leff outputs.
  always_comb begin
    k_d   = '0;
    seg_d = 1'b0;
    if (vld_q) begin
      seg_d = 1'b1;
    end else if (seg_q && (k_q != last_idx)) begin
      k_d   = k_q + PW'(1);
      seg_d = 1'b1;
    end
  end

  // Output sample selection; outside a segment the output rests at zero.
  always_comb begin
    inter_d     = '0;
    out_valid_d = seg_q;
    if (seg_q) begin
      case (mode_q)
        M_ZERO:   inter_d = (k_q == '0) ? x_cur_q : '0;
        M_LINEAR: inter_d = lin_val;
        default:  inter_d = x_cur_q;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= 1'b0;
      x_prev_q    <= '0;
      x_cur_q     <= '0;
      k_q         <= '0;
      seg_q       <= 1'b0;
      inter_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      vld_q       <= rd_en;
      x_prev_q    <= x_prev_d;
      x_cur_q     <= x_cur_d;
      k_q         <= k_d;
      seg_q       <= seg_d;
      inter_q     <= inter_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.rd_en      = rd_en;
  assign bus.inter_data = inter_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.underflow  = underflow_q;

endmodule

// File: doc/interp_upsampler.md
# interp_upsampler

Parametrised successor to the pass-through DAC feeder. Reads signed samples from the upstream sample FIFO and produces one output sample per clock at L = 2^FACTOR_LOG2 times the input rate. It supports four runtime-selectable modes: bypass, zero-stuff, hold and linear interpolation. It sits between the FIFO read side and the DAC data path, and adds underflow detection plus an output-valid qualifier.

## Interface
- DATA_WIDTH, 14, sample width (signed, two's complement)
- FACTOR_LOG2, 2, log2 of interpolation factor L; legal range 1..4
- clk  in  1  sample/DAC clock
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  FIFO above-half flag; start condition
- empty  in  1  FIFO empty flag
- mode  in  2  0 bypass, 1 zero-stuff, 2 hold, 3 linear
- rd_en  out  1  FIFO read enable; FIFO read latency is 1 cycle
- dataIn  in  DATA_WIDTH  FIFO read data, valid the cycle after rd_en
- inter_data  out  DATA_WIDTH  interpolated sample, registered
- out_valid  out  1  inter_data carries a valid sample
- underflow  out  1  sticky underflow flag

## Operation
- FSM states: IDLE, RUN.
- IDLE -> RUN when ena=1 and empty=0.
  - On this transition: latch mode into mode_q, clear phase, x_prev and x_cur.
- RUN -> IDLE on underflow only. Deassertion of ena in RUN is ignored (above-half acts as the start event, then the block streams continuously). mode changes in RUN are ignored until the next IDLE->RUN.
- Effective factor: Leff = 1 when mode_q=0, otherwise L.
- phase counter: 0..Leff-1 in RUN, increments every cycle and wraps to 0.
- rd_en (combinational) = RUN & phase==0 & ~empty.
- Underflow: RUN & phase==0 & empty=1. In that cycle:
  - rd_en=0.
  - FSM -> IDLE, underflow <= 1.
  - underflow stays 1 until rst_n.
- Capture: vld_d = rd_en delayed 1. When vld_d=1, x_prev <= x_cur and x_cur <= dataIn.
- Output stage: for each captured sample, generate Leff outputs with index k = 0..Leff-1, registered into inter_data.
  - bypass: x_cur
  - zero-stuff: k==0 ? x_cur : 0
  - hold: x_cur
  - linear: x_prev + ((x_cur - x_prev) * k) >>> FACTOR_LOG2
- Linear width rules:
  - difference is DATA_WIDTH+1 bits signed.
  - product is DATA_WIDTH+1+FACTOR_LOG2 bits signed.
  - shift is arithmetic (floor rounding).
  - result lies between x_prev and x_cur, so it is truncated to DATA_WIDTH with no saturation.
- First linear segment after entering RUN ramps from x_prev=0.
- After underflow, samples already read complete their full Leff-sample segment. Then out_valid=0 and inter_data=0.
- Restart from IDLE needs ena=1 and empty=0 again.

## Timing
- Reset values: rd_en=0, inter_data=0, out_valid=0, underflow=0; FSM=IDLE, phase=0, x_prev=x_cur=0.
- rst_n assertion mid-stream forces the reset values immediately. The partial segment is discarded.
- Latency: rd_en high in cycle t -> dataIn valid t+1 -> captured at end of t+1.
  - First output of that segment on inter_data in cycle t+3, with out_valid=1.
  - Same 3-cycle latency in every mode.
- With no underflow, out_valid stays high continuously from the first segment onward: one sample every cycle, no gaps.
- rd_en rate: every cycle in bypass; one cycle in every L in other modes.
- out_valid falls 3 cycles after the last phase==Leff-1 cycle of the final captured segment.
- A simultaneous ena=1 and underflow in the same cycle does not restart the block. IDLE is entered first, and the restart is evaluated from the next cycle.

## Test plan
- Reset: hold rst_n=0 with ena=1, dataIn=123 -> rd_en=0, inter_data=0, out_valid=0, underflow=0. Release rst_n; ena=1 and empty=0 -> first rd_en on the next cycle.
- Bypass, FACTOR_LOG2=2: FIFO supplies 100, 200, 300 -> rd_en high every cycle; inter_data = 100, 200, 300 on consecutive cycles, starting 3 cycles after the first rd_en.
- Hold and zero-stuff, L=4, samples 100, -100:
  - hold -> 100,100,100,100,-100,-100,-100,-100.
  - zero-stuff -> 100,0,0,0,-100,0,0,0.
  - rd_en pulses every 4th cycle.
- Linear, L=4:
  - samples 400, 800 -> 0,100,200,300,400,500,600,700.
  - samples -3 from zero -> 0,-1,-2,-3.
  - x_prev=8191, x_cur=-8192, k=3 -> -4097 (no overflow).
- Underflow: raise empty at a phase==0 cycle mid-stream ->
  - rd_en stays 0 and underflow=1.
  - remaining segment outputs complete, then out_valid=0 and inter_data=0.
  - reassert ena with empty=0 -> streaming resumes; underflow remains 1 until rst_n.
- Mode change and ena drop in RUN: toggle mode 2->3 and drop ena -> output keeps hold behaviour with no gaps. The new mode takes effect only after the next underflow/restart or reset.
